// File: rtl/ext_pkg.sv
// ext_pkg: op encoding and the immediate/load-data extension function
package ext_pkg;
  typedef enum logic [2:0] {
    EXT_ZEXT = 3'd0,
    EXT_SEXT = 3'd1,
    EXT_LUI  = 3'd2,
    EXT_LB   = 3'd3,
    EXT_LBU  = 3'd4,
    EXT_LH   = 3'd5,
    EXT_LHU  = 3'd6,
    EXT_LW   = 3'd7
  } ext_op_e;
  // Computes {exc, data} at the widest supported width (64); callers keep the low DATA_W bits,
  // which is exact because every result is either zero- or sign-replicated above DATA_W.
  function automatic logic [64:0] ext_calc(input ext_op_e op, input logic [31:0] imm,
                                           input logic [63:0] word, input logic [2:0] ofs,
                                           input int unsigned imm_w);
    logic [63:0] lo_mask, im, lane, d;
    logic sg, exc;
    lo_mask = (64'd1 << imm_w) - 64'd1;
    im = {32'd0, imm} & lo_mask;
    sg = |(im & (64'd1 << (imm_w - 1)));
    lane = word >> {ofs, 3'b000};
    unique case (op)
      EXT_ZEXT: d = im;
      EXT_SEXT: d = sg ? (im | ~lo_mask) : im;
      EXT_LUI:  d = (im << imm_w) | (sg ? ~((lo_mask << imm_w) | lo_mask) : 64'd0);
      EXT_LB:   d = {{56{lane[7]}}, lane[7:0]};
      EXT_LBU:  d = {56'd0, lane[7:0]};
      EXT_LH:   d = {{48{lane[15]}}, lane[15:0]};
      EXT_LHU:  d = {48'd0, lane[15:0]};
      default:  d = word;
    endcase
    exc = ((op == EXT_LH || op == EXT_LHU) && ofs[0]) || (op == EXT_LW && ofs != 3'd0);
    return {exc, exc ? 64'd0 : d};
  endfunction
endpackage

// File: rtl/ext_skid.sv
// ext_skid: one-stage valid/ready register with a one-entry skid buffer and registered in_ready
module ext_skid #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;
  state_e state_q, state_d;
  logic [W-1:0] m_q, m_d, s_q, s_d;
  logic rdy_q, acc, xfer;
  assign acc = in_valid && rdy_q;
  assign xfer = (state_q != EMPTY) && out_ready;
  assign in_ready = rdy_q;
  assign out_valid = state_q != EMPTY;
  assign out_data = m_q;
  // Next-state and storage moves; the skid entry always drains into M before anything newer.
  always_comb begin
    state_d = state_q;
    m_d = m_q;
    s_d = s_q;
    unique case (state_q)
      EMPTY: if (acc) begin
        m_d = in_data;
        state_d = ONE;
      end
      ONE: if (acc && xfer) m_d = in_data;
        else if (acc) begin
          s_d = in_data;
          state_d = FULL;
        end else if (xfer) state_d = EMPTY;
      FULL: if (xfer) begin
        m_d = s_q;
        state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end
  // State and payload registers; in_ready is registered from the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= EMPTY;
      m_q <= '0;
      s_q <= '0;
      rdy_q <= 1'b1;
    end else begin
      state_q <= state_d;
      m_q <= m_d;
      s_q <= s_d;
      rdy_q <= state_d != FULL;
    end
  end
endmodule

// File: rtl/ext_unit.sv
// ext_unit: registered immediate/load-data extension with alignment check and skid handshake
module ext_unit
  import ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W = 16,
  localparam int OFS_W = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [DATA_W-1:0] in_word,
  input  logic [OFS_W-1:0]  in_ofs,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_exc
);
  logic [64:0] calc;
  logic calc_unused;
  logic [DATA_W:0] pay_in, pay_out;
  assign calc = ext_calc(ext_op_e'(in_op), 32'(in_imm), 64'(in_word), 3'(in_ofs), IMM_W);
  assign calc_unused = ^calc;
  assign pay_in = {calc[64], calc[DATA_W-1:0]};
  assign out_exc = pay_out[DATA_W];
  assign out_data = pay_out[DATA_W-1:0];
  ext_skid #(.W(DATA_W + 1)) u_skid (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(pay_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(pay_out)
  );
endmodule

// File: tb/tb_ext_unit.sv
// tb_ext_unit: directed and randomized checks of ext_unit against a scoreboard model
module tb_ext_unit;
  logic clk = 1'b0, rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_exc;
  logic [2:0] in_op;
  logic [15:0] in_imm;
  logic [31:0] in_word, out_data;
  logic [1:0] in_ofs;
  logic v64, rdy64, ov64, exc64;
  logic [2:0] op64;
  logic [15:0] imm64;
  logic [63:0] word64, od64;
  logic [2:0] ofs64;
  int errors = 0, checks = 0;
  logic [32:0] q[$];
  logic stall_prev = 1'b0;
  logic [32:0] held = '0;
  logic acc;
  int idx, n;
  logic [2:0] bp_op[6] = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd5};
  logic [1:0] bp_ofs[6] = '{2'd3, 2'd2, 2'd2, 2'd0, 2'd0, 2'd1};

  always #5 clk = ~clk;

  ext_unit #(.DATA_W(32), .IMM_W(16)) dut (
    .clk(clk), .reset(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_imm(in_imm), .in_word(in_word), .in_ofs(in_ofs),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_exc(out_exc)
  );

  ext_unit #(.DATA_W(64), .IMM_W(16)) dut64 (
    .clk(clk), .reset(rst_n), .flush(1'b0), .in_valid(v64), .in_ready(rdy64),
    .in_op(op64), .in_imm(imm64), .in_word(word64), .in_ofs(ofs64),
    .out_valid(ov64), .out_ready(1'b1), .out_data(od64), .out_exc(exc64)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic [2:0] op, input logic [15:0] imm,
                                        input logic [31:0] w, input logic [1:0] o);
    longint u, b, h, r;
    logic mis;
    u = longint'(imm);
    b = (longint'(w) >> (8 * o)) % 256;
    h = (longint'(w) >> (8 * o)) % 65536;
    mis = 1'b0;
    case (op)
      3'd0: r = u;
      3'd1: r = (u >= 32768) ? u - 65536 : u;
      3'd2: r = u * 65536;
      3'd3: r = (b >= 128) ? b - 256 : b;
      3'd4: r = b;
      3'd5: begin r = (h >= 32768) ? h - 65536 : h; mis = (o % 2) == 1; end
      3'd6: begin r = h; mis = (o % 2) == 1; end
      default: begin r = longint'(w); mis = o != 2'd0; end
    endcase
    return mis ? {1'b1, 32'd0} : {1'b0, r[31:0]};
  endfunction

  task automatic cyc(input logic v, input logic r, input logic f, input logic [2:0] op,
                     input logic [15:0] imm, input logic [31:0] w, input logic [1:0] o,
                     output logic accepted);
    in_valid = v; out_ready = r; flush = f; in_op = op; in_imm = imm; in_word = w; in_ofs = o;
    #1;
    accepted = rst_n && !f && in_valid && in_ready;
    if (rst_n) begin
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      if (stall_prev) chk("hold", 64'({out_exc, out_data}), 64'(held));
      if (out_valid && out_ready && !f && q.size() > 0) chk("data", 64'({out_exc, out_data}), 64'(q.pop_front()));
      if (accepted) q.push_back(model(op, imm, w, o));
      if (f) q.delete();
      stall_prev = out_valid && !out_ready && !f;
      held = {out_exc, out_data};
    end else begin
      q.delete();
      stall_prev = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic dir(input string tag, input logic [2:0] op, input logic [15:0] imm,
                     input logic [31:0] w, input logic [1:0] o, input logic [32:0] exp);
    logic a;
    cyc(1'b1, 1'b1, 1'b0, op, imm, w, o, a);
    chk(tag, 64'({out_valid, out_exc, out_data}), 64'({1'b1, exp}));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; v64 = 1'b0; op64 = 3'd0; imm64 = '0; word64 = '0; ofs64 = '0;
    @(negedge clk);
    cyc(1'b1, 1'b0, 1'b0, 3'd7, 16'h0, 32'hDEADBEEF, 2'd0, acc);
    cyc(1'b1, 1'b0, 1'b0, 3'd7, 16'h0, 32'hDEADBEEF, 2'd0, acc);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'({out_exc, out_data}), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    dir("zext", 3'd0, 16'h8001, 32'h0, 2'd0, 33'h0_0000_8001);
    dir("sext", 3'd1, 16'h8001, 32'h0, 2'd0, 33'h0_FFFF_8001);
    dir("lui", 3'd2, 16'h1234, 32'h0, 2'd0, 33'h0_1234_0000);
    dir("lb3", 3'd3, 16'h0, 32'h80FF7F01, 2'd3, 33'h0_FFFF_FF80);
    dir("lbu2", 3'd4, 16'h0, 32'h80FF7F01, 2'd2, 33'h0_0000_00FF);
    dir("lh2", 3'd5, 16'h0, 32'h80FF7F01, 2'd2, 33'h0_FFFF_80FF);
    dir("lhu0", 3'd6, 16'h0, 32'h80FF7F01, 2'd0, 33'h0_0000_7F01);
    dir("lw0", 3'd7, 16'h0, 32'h80FF7F01, 2'd0, 33'h0_80FF_7F01);
    dir("lh1_exc", 3'd5, 16'h0, 32'h80FF7F01, 2'd1, 33'h1_0000_0000);
    dir("lw2_exc", 3'd7, 16'h0, 32'h80FF7F01, 2'd2, 33'h1_0000_0000);
    cyc(1'b0, 1'b1, 1'b0, 3'd0, 16'h0, 32'h0, 2'd0, acc);
    chk("rdy64", 64'(rdy64), 64'd1);
    v64 = 1'b1; op64 = 3'd2; imm64 = 16'h8001;
    @(negedge clk);
    v64 = 1'b0;
    chk("lui64", {63'(ov64), 1'b0} | 64'(exc64), 64'd2);
    chk("lui64_data", od64, 64'hFFFF_FFFF_8001_0000);
    idx = 0; n = 0;
    while ((idx < 6 || q.size() > 0) && n < 40) begin
      cyc(idx < 6, n >= 3, 1'b0, bp_op[idx % 6], 16'h0, 32'h80FF7F01, bp_ofs[idx % 6], acc);
      if (acc) idx++;
      if (n == 1) chk("bp_ready_drop", 64'({in_ready, 3'(idx)}), 64'({1'b0, 3'd2}));
      n++;
    end
    chk("bp_cycles", 64'(n), 64'd9);
    cyc(1'b1, 1'b0, 1'b0, 3'd1, 16'h7FFF, 32'h0, 2'd0, acc);
    cyc(1'b1, 1'b0, 1'b0, 3'd1, 16'hFFFF, 32'h0, 2'd0, acc);
    chk("full_ready", 64'(in_ready), 64'd0);
    cyc(1'b1, 1'b0, 1'b1, 3'd0, 16'h5555, 32'h0, 2'd0, acc);
    chk("flush_full", 64'({out_valid, in_ready}), 64'b01);
    cyc(1'b1, 1'b0, 1'b0, 3'd0, 16'h1111, 32'h0, 2'd0, acc);
    cyc(1'b1, 1'b1, 1'b1, 3'd0, 16'h2222, 32'h0, 2'd0, acc);
    chk("flush_one", 64'({out_valid, in_ready}), 64'b01);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 3'd0, 16'h0, 32'h0, 2'd0, acc);
    cyc(1'b1, 1'b0, 1'b0, 3'd0, 16'h3333, 32'h0, 2'd0, acc);
    cyc(1'b1, 1'b0, 1'b0, 3'd0, 16'h4444, 32'h0, 2'd0, acc);
    rst_n = 1'b0;
    cyc(1'b1, 1'b1, 1'b0, 3'd0, 16'h0, 32'h0, 2'd0, acc);
    chk("midrst", 64'({out_valid, in_ready, out_exc, out_data}), {30'd0, 2'b01, 33'd0});
    rst_n = 1'b1;
    for (int i = 0; i < 10000; i++)
      cyc($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 60, $urandom_range(0, 199) == 0,
          3'($urandom), 16'($urandom), $urandom, 2'($urandom), acc);
    n = 0;
    while (q.size() > 0 && n < 10) begin
      cyc(1'b0, 1'b1, 1'b0, 3'd0, 16'h0, 32'h0, 2'd0, acc);
      n++;
    end
    chk("drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
